// File: rtl/mips_define.sv
`default_nettype none
// ============================================================================
// Module      : mips_define
// Description : Shared MIPS64r6 major opcode and SPECIAL funct values.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_define;

  // Major opcodes (instruction bits 31:26)
  localparam logic [5:0] OP_OTHER0 = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_DADDIU = 6'h19;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_LD     = 6'h37;
  localparam logic [5:0] OP_SD     = 6'h3F;

  // SPECIAL (OP_OTHER0) funct codes (instruction bits 5:0)
  localparam logic [5:0] FN_SLL    = 6'h00;
  localparam logic [5:0] FN_SRL    = 6'h02;
  localparam logic [5:0] FN_SRA    = 6'h03;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUBU   = 6'h23;
  localparam logic [5:0] FN_AND    = 6'h24;
  localparam logic [5:0] FN_OR     = 6'h25;
  localparam logic [5:0] FN_XOR    = 6'h26;
  localparam logic [5:0] FN_NOR    = 6'h27;
  localparam logic [5:0] FN_SLT    = 6'h2A;
  localparam logic [5:0] FN_SLTU   = 6'h2B;
  localparam logic [5:0] FN_DADDU  = 6'h2D;
  localparam logic [5:0] FN_DSLL   = 6'h38;
  localparam logic [5:0] FN_DSRL   = 6'h3A;
  localparam logic [5:0] FN_DSRA   = 6'h3B;
  localparam logic [5:0] FN_DSLL32 = 6'h3C;
  localparam logic [5:0] FN_DSRL32 = 6'h3E;

endpackage
`default_nettype wire

// File: rtl/mips_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_enc_pkg
// Description : Command kinds, field positions and the combinational
//               instruction encode function for mips_inst_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_enc_pkg;
  import mips_define::*;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SA_LSB = 6;
  localparam int KIND_W = 6;
  localparam int WORD_W = 32;

  typedef enum logic [KIND_W-1:0] {
    K_NOP, K_ADDU, K_SUBU, K_AND, K_OR, K_XOR, K_NOR, K_SLT, K_SLTU, K_DADDU,
    K_SLL, K_SRL, K_SRA, K_DSLL, K_DSRL, K_DSRA,
    K_ADDIU, K_DADDIU, K_SLTI, K_SLTIU, K_ANDI, K_ORI, K_XORI,
    K_LB, K_LH, K_LW, K_LBU, K_LHU, K_LD, K_SB, K_SH, K_SW, K_SD,
    K_BEQ, K_BNE, K_LUI, K_J, K_JAL, K_LI
  } enc_kind_t;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_EMIT2 = 1'b1
  } enc_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] word0;
    logic [WORD_W-1:0] word1;
    logic              two_words;
    logic              illegal;
  } enc_result_t;

  function automatic logic [WORD_W-1:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                              input logic [4:0] rd, input logic [4:0] sa,
                                              input logic [5:0] fn);
    logic [WORD_W-1:0] w;
    w = '0;
    w[OP_LSB +: 6] = OP_OTHER0;
    w[RS_LSB +: 5] = rs;
    w[RT_LSB +: 5] = rt;
    w[RD_LSB +: 5] = rd;
    w[SA_LSB +: 5] = sa;
    w[5:0]         = fn;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                              input logic [4:0] rt, input logic [15:0] imm);
    logic [WORD_W-1:0] w;
    w = '0;
    w[OP_LSB +: 6] = op;
    w[RS_LSB +: 5] = rs;
    w[RT_LSB +: 5] = rt;
    w[15:0]        = imm;
    return w;
  endfunction

  // Encode one command; LI may expand to a LUI/ORI pair in word0/word1.
  function automatic enc_result_t mips_encode(input logic [KIND_W-1:0] kind,
                                              input logic [4:0] rs, input logic [4:0] rt,
                                              input logic [4:0] rd, input logic [5:0] shamt,
                                              input logic [31:0] imm);
    enc_result_t r;
    r = '0;
    case (kind)
      K_NOP:    r.word0 = '0;
      K_ADDU:   r.word0 = enc_r(rs, rt, rd, 5'd0, FN_ADDU);
      K_SUBU:   r.word0 = enc_r(rs, rt, rd, 5'd0, FN_SUBU);
      K_AND:    r.word0 = enc_r(rs, rt, rd, 5'd0, FN_AND);
      K_OR:     r.word0 = enc_r(rs, rt, rd, 5'd0, FN_OR);
      K_XOR:    r.word0 = enc_r(rs, rt, rd, 5'd0, FN_XOR);
      K_NOR:    r.word0 = enc_r(rs, rt, rd, 5'd0, FN_NOR);
      K_SLT:    r.word0 = enc_r(rs, rt, rd, 5'd0, FN_SLT);
      K_SLTU:   r.word0 = enc_r(rs, rt, rd, 5'd0, FN_SLTU);
      K_DADDU:  r.word0 = enc_r(rs, rt, rd, 5'd0, FN_DADDU);
      K_SLL: begin
        r.word0   = enc_r(5'd0, rt, rd, shamt[4:0], FN_SLL);
        r.illegal = shamt[5];
      end
      K_SRL: begin
        r.word0   = enc_r(5'd0, rt, rd, shamt[4:0], FN_SRL);
        r.illegal = shamt[5];
      end
      K_SRA: begin
        r.word0   = enc_r(5'd0, rt, rd, shamt[4:0], FN_SRA);
        r.illegal = shamt[5];
      end
      // Shift amounts of 32..63 use the "+32" funct with the low five bits as sa.
      K_DSLL:   r.word0 = enc_r(5'd0, rt, rd, shamt[4:0], shamt[5] ? FN_DSLL32 : FN_DSLL);
      K_DSRL:   r.word0 = enc_r(5'd0, rt, rd, shamt[4:0], shamt[5] ? FN_DSRL32 : FN_DSRL);
      K_DSRA: begin
        r.word0   = enc_r(5'd0, rt, rd, shamt[4:0], FN_DSRA);
        r.illegal = shamt[5];
      end
      K_ADDIU:  r.word0 = enc_i(OP_ADDIU,  rs, rt, imm[15:0]);
      K_DADDIU: r.word0 = enc_i(OP_DADDIU, rs, rt, imm[15:0]);
      K_SLTI:   r.word0 = enc_i(OP_SLTI,   rs, rt, imm[15:0]);
      K_SLTIU:  r.word0 = enc_i(OP_SLTIU,  rs, rt, imm[15:0]);
      K_ANDI:   r.word0 = enc_i(OP_ANDI,   rs, rt, imm[15:0]);
      K_ORI:    r.word0 = enc_i(OP_ORI,    rs, rt, imm[15:0]);
      K_XORI:   r.word0 = enc_i(OP_XORI,   rs, rt, imm[15:0]);
      K_LB:     r.word0 = enc_i(OP_LB,     rs, rt, imm[15:0]);
      K_LH:     r.word0 = enc_i(OP_LH,     rs, rt, imm[15:0]);
      K_LW:     r.word0 = enc_i(OP_LW,     rs, rt, imm[15:0]);
      K_LBU:    r.word0 = enc_i(OP_LBU,    rs, rt, imm[15:0]);
      K_LHU:    r.word0 = enc_i(OP_LHU,    rs, rt, imm[15:0]);
      K_LD:     r.word0 = enc_i(OP_LD,     rs, rt, imm[15:0]);
      K_SB:     r.word0 = enc_i(OP_SB,     rs, rt, imm[15:0]);
      K_SH:     r.word0 = enc_i(OP_SH,     rs, rt, imm[15:0]);
      K_SW:     r.word0 = enc_i(OP_SW,     rs, rt, imm[15:0]);
      K_SD:     r.word0 = enc_i(OP_SD,     rs, rt, imm[15:0]);
      K_BEQ:    r.word0 = enc_i(OP_BEQ,    rs, rt, imm[15:0]);
      K_BNE:    r.word0 = enc_i(OP_BNE,    rs, rt, imm[15:0]);
      K_LUI:    r.word0 = enc_i(OP_LUI,    5'd0, rt, imm[15:0]);
      K_J:      r.word0 = {OP_J,   imm[25:0]};
      K_JAL:    r.word0 = {OP_JAL, imm[25:0]};
      K_LI: begin
        // Sign-extended 16-bit value: bits 31..15 all equal.
        if ((&imm[31:15]) || !(|imm[31:15])) begin
          r.word0 = enc_i(OP_ADDIU, 5'd0, rt, imm[15:0]);
        end else if (imm[15:0] == 16'd0) begin
          r.word0 = enc_i(OP_LUI, 5'd0, rt, imm[31:16]);
        end else begin
          r.word0     = enc_i(OP_LUI, 5'd0, rt, imm[31:16]);
          r.word1     = enc_i(OP_ORI, rt, rt, imm[15:0]);
          r.two_words = 1'b1;
        end
      end
      default:  r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_enc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mips_enc_fifo
// Description : Two-entry FIFO of {last, word} with count-based full/empty.
//               A pop in the same cycle as a push frees the slot, so a full
//               FIFO can still accept a push while it is being drained.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_enc_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             can_push,
  output logic             valid,
  output logic [WIDTH-1:0] head_data
);

  localparam logic [1:0] c_full = 2'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  assign valid     = (r_count != 2'd0);
  assign can_push  = (r_count != c_full) || pop;
  assign head_data = valid ? r_mem[r_rd_ptr] : '0;

  // Storage, pointers and occupancy; reset discards every pending entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : mips_inst_encoder
// Description : Converts structured instruction commands into MIPS64r6 words,
//               expanding LI into one or two words, with a 2-entry output
//               FIFO and a saturating illegal-command counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_inst_encoder
  import mips_enc_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int ERRW       = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [5:0]      cmd_kind,
  input  logic [4:0]      cmd_rs,
  input  logic [4:0]      cmd_rt,
  input  logic [4:0]      cmd_rd,
  input  logic [5:0]      cmd_shamt,
  input  logic [31:0]     cmd_imm,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_word,
  output logic            inst_last,
  output logic            err_pulse,
  output logic [ERRW-1:0] err_count
);

  enc_state_t       r_state;
  enc_state_t       w_state_nxt;
  enc_result_t      w_enc;
  logic             r_run;
  logic [31:0]      r_word1;
  logic             r_err_pulse;
  logic [ERRW-1:0]  r_err_count;
  logic             w_accept;
  logic             w_push;
  logic [32:0]      w_push_data;
  logic             w_pop;
  logic             w_can_push;
  logic             w_fifo_valid;
  logic [32:0]      w_head;

  assign w_enc     = mips_encode(cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_imm);
  assign cmd_ready = r_run && (r_state == S_IDLE) && w_can_push;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_pop     = w_fifo_valid && inst_ready;

  // Holds cmd_ready low throughout reset and for the first cycle after release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and FIFO push selection.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_data = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_enc.illegal) begin
          w_push      = 1'b1;
          w_push_data = {!w_enc.two_words, w_enc.word0};
          if (w_enc.two_words) begin
            w_state_nxt = S_EMIT2;
          end
        end
      end
      S_EMIT2: begin
        if (w_can_push) begin
          w_push      = 1'b1;
          w_push_data = {1'b1, r_word1};
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Second LI word waits here until the FIFO has room.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_word1 <= '0;
    end else if (w_accept && w_enc.two_words) begin
      r_word1 <= w_enc.word1;
    end
  end

  // Illegal-command pulse and saturating counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_accept && w_enc.illegal;
      if (w_accept && w_enc.illegal && (r_err_count != {ERRW{1'b1}})) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  mips_enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .can_push  (w_can_push),
    .valid     (w_fifo_valid),
    .head_data (w_head)
  );

  assign inst_valid = w_fifo_valid;
  assign inst_word  = w_head[31:0];
  assign inst_last  = w_head[32];
  assign err_pulse  = r_err_pulse;
  assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_inst_encoder
// Description : Scoreboard bench for mips_inst_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_inst_encoder;
  import mips_enc_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_kind = '0;
  logic [4:0]  cmd_rs = '0;
  logic [4:0]  cmd_rt = '0;
  logic [4:0]  cmd_rd = '0;
  logic [5:0]  cmd_shamt = '0;
  logic [31:0] cmd_imm = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_word;
  logic        inst_last;
  logic        err_pulse;
  logic [7:0]  err_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [32:0] exp_q[$];

  always #5 clock = ~clock;

  mips_inst_encoder #(.FIFO_DEPTH(2), .ERRW(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_kind   (cmd_kind),
    .cmd_rs     (cmd_rs),
    .cmd_rt     (cmd_rt),
    .cmd_rd     (cmd_rd),
    .cmd_shamt  (cmd_shamt),
    .cmd_imm    (cmd_imm),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_word  (inst_word),
    .inst_last  (inst_last),
    .err_pulse  (err_pulse),
    .err_count  (err_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder for the kinds used in the random phase.
  function automatic void tb_enc(input logic [5:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [5:0] sa, input logic [31:0] imm,
                                 output logic [32:0] e0, output logic [32:0] e1, output int n);
    n  = 1;
    e0 = '0;
    e1 = '0;
    case (k)
      K_ADDU: e0 = {1'b1, 6'h00, rs, rt, rd, 5'h00, 6'h21};
      K_OR:   e0 = {1'b1, 6'h00, rs, rt, rd, 5'h00, 6'h25};
      K_SRL:  e0 = {1'b1, 6'h00, 5'h00, rt, rd, sa[4:0], 6'h02};
      K_ORI:  e0 = {1'b1, 6'h0D, rs, rt, imm[15:0]};
      K_LW:   e0 = {1'b1, 6'h23, rs, rt, imm[15:0]};
      K_J:    e0 = {1'b1, 6'h02, imm[25:0]};
      K_NOP:  e0 = {1'b1, 32'h0};
      K_LI: begin
        if (imm[31:15] == 17'h0 || imm[31:15] == 17'h1FFFF) begin
          e0 = {1'b1, 6'h09, 5'd0, rt, imm[15:0]};
        end else if (imm[15:0] == 16'h0) begin
          e0 = {1'b1, 6'h0F, 5'd0, rt, imm[31:16]};
        end else begin
          n  = 2;
          e0 = {1'b0, 6'h0F, 5'd0, rt, imm[31:16]};
          e1 = {1'b1, 6'h0D, rt, rt, imm[15:0]};
        end
      end
      default: n = 0;
    endcase
  endfunction

  // Output side of the scoreboard: every transfer must match the queue head.
  always @(negedge clock) begin
    if (reset_n && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_word", {32'h1, inst_word}, 64'h0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check_eq("word", {32'h0, inst_word}, {32'h0, e[31:0]});
        check_eq("last", {63'h0, inst_last}, {63'h0, e[32]});
      end
    end
  end

  task automatic drive_cmd(input logic [5:0] k, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [5:0] sa, input logic [31:0] imm);
    @(posedge clock);
    #1;
    cmd_kind  = k;
    cmd_rs    = rs;
    cmd_rt    = rt;
    cmd_rd    = rd;
    cmd_shamt = sa;
    cmd_imm   = imm;
    cmd_valid = 1'b1;
  endtask

  // Waits for acceptance, queues the expected words, then drops cmd_valid.
  task automatic wait_accept(input int n, input logic [32:0] e0, input logic [32:0] e1,
                             input bit rnd);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clock);
      if (cmd_ready) begin
        if (n >= 1) exp_q.push_back(e0);
        if (n >= 2) exp_q.push_back(e1);
        done = 1'b1;
      end
      @(posedge clock);
      #1;
      if (!done && rnd) inst_ready = 1'($urandom_range(0, 1));
    end
    cmd_valid = 1'b0;
    if (!done) check_eq("accept_timeout", 64'h0, 64'h1);
  endtask

  task automatic send(input logic [5:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] sa, input logic [31:0] imm,
                      input int n, input logic [32:0] e0, input logic [32:0] e1);
    drive_cmd(k, rs, rt, rd, sa, imm);
    wait_accept(n, e0, e1, 1'b0);
  endtask

  task automatic send_model(input logic [5:0] k, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [5:0] sa, input logic [31:0] imm,
                            input bit rnd);
    logic [32:0] e0, e1;
    int n;
    tb_enc(k, rs, rt, rd, sa, imm, e0, e1, n);
    drive_cmd(k, rs, rt, rd, sa, imm);
    wait_accept(n, e0, e1, rnd);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clock);
    repeat (2) @(negedge clock);
    check_eq("drain", 64'(exp_q.size()), 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    logic [5:0]  kinds [7];
    logic [31:0] imm;
    kinds = '{K_ADDU, K_OR, K_SRL, K_ORI, K_LW, K_J, K_LI};

    // Reset state
    repeat (3) @(negedge clock);
    check_eq("rst_cmd_ready",  {63'h0, cmd_ready},  64'h0);
    check_eq("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
    check_eq("rst_inst_word",  {32'h0, inst_word},  64'h0);
    check_eq("rst_inst_last",  {63'h0, inst_last},  64'h0);
    check_eq("rst_err_pulse",  {63'h0, err_pulse},  64'h0);
    check_eq("rst_err_count",  {56'h0, err_count},  64'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // ADDU, visible the cycle after acceptance
    send(K_ADDU, 5'd1, 5'd2, 5'd3, 6'd0, 32'h0, 1, {1'b1, 32'h00221821}, '0);
    @(negedge clock);
    check_eq("addu_latency_valid", {63'h0, inst_valid}, 64'h1);
    check_eq("addu_head_word", {32'h0, inst_word}, 64'h00221821);
    @(posedge clock);
    #1 inst_ready = 1'b1;
    drain();

    // LI two-word, cmd_ready low during the second word
    send(K_LI, 5'd0, 5'd4, 5'd0, 6'd0, 32'h12345678, 2,
         {1'b0, 32'h3C041234}, {1'b1, 32'h34845678});
    @(negedge clock);
    check_eq("li_emit2_cmd_ready", {63'h0, cmd_ready}, 64'h0);
    drain();

    // Single-word LI forms, DSLL promotion, NOP
    send(K_LI,   5'd0, 5'd5, 5'd0, 6'd0,  32'hFFFF8000, 1, {1'b1, 32'h24058000}, '0);
    send(K_LI,   5'd0, 5'd6, 5'd0, 6'd0,  32'h00010000, 1, {1'b1, 32'h3C060001}, '0);
    send(K_DSLL, 5'd0, 5'd3, 5'd2, 6'd40, 32'h0,        1, {1'b1, 32'h0003123C}, '0);
    send(K_NOP,  5'd7, 5'd7, 5'd7, 6'd0,  32'hFFFFFFFF, 1, {1'b1, 32'h00000000}, '0);
    drain();

    // DSRA with shamt 40 is illegal: no word, one-cycle error pulse
    send(K_DSRA, 5'd0, 5'd3, 5'd2, 6'd40, 32'h0, 0, '0, '0);
    @(negedge clock);
    check_eq("dsra_err_pulse", {63'h0, err_pulse}, 64'h1);
    check_eq("dsra_no_word", {63'h0, inst_valid}, 64'h0);
    @(negedge clock);
    check_eq("dsra_pulse_width", {63'h0, err_pulse}, 64'h0);
    check_eq("dsra_err_count", {56'h0, err_count}, 64'h1);

    // Undefined kind and SLL with shamt > 31
    send(6'd63, 5'd0, 5'd0, 5'd0, 6'd0,  32'h0, 0, '0, '0);
    send(K_SLL, 5'd0, 5'd1, 5'd1, 6'd33, 32'h0, 0, '0, '0);
    repeat (2) @(negedge clock);
    check_eq("illegal_err_count", {56'h0, err_count}, 64'h3);
    check_eq("illegal_no_word", {63'h0, inst_valid}, 64'h0);

    // Backpressure: LI pair fills the FIFO, ADDU must wait
    @(posedge clock);
    #1 inst_ready = 1'b0;
    send(K_LI, 5'd0, 5'd4, 5'd0, 6'd0, 32'h12345678, 2,
         {1'b0, 32'h3C041234}, {1'b1, 32'h34845678});
    drive_cmd(K_ADDU, 5'd1, 5'd2, 5'd3, 6'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("bp_cmd_ready", {63'h0, cmd_ready}, 64'h0);
      check_eq("bp_head_word", {32'h0, inst_word}, 64'h3C041234);
      check_eq("bp_head_last", {63'h0, inst_last}, 64'h0);
    end
    @(posedge clock);
    #1 inst_ready = 1'b1;
    wait_accept(1, {1'b1, 32'h00221821}, '0, 1'b0);
    drain();

    // Random mix with random backpressure
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       imm = $urandom_range(0, 32'h7FFF);
        1:       imm = {16'($urandom), 16'h0};
        default: imm = $urandom;
      endcase
      send_model(kinds[$urandom_range(0, 6)], 5'($urandom), 5'($urandom), 5'($urandom),
                 6'($urandom_range(0, 31)), imm, 1'b1);
    end
    @(posedge clock);
    #1 inst_ready = 1'b1;
    drain();

    // Reset while stuck in EMIT2 with a full FIFO
    @(posedge clock);
    #1 inst_ready = 1'b0;
    send(K_ADDU, 5'd1, 5'd2, 5'd3, 6'd0, 32'h0, 1, {1'b1, 32'h00221821}, '0);
    send(K_LI, 5'd0, 5'd4, 5'd0, 6'd0, 32'h12345678, 2,
         {1'b0, 32'h3C041234}, {1'b1, 32'h34845678});
    @(negedge clock);
    check_eq("emit2_stall_cmd_ready", {63'h0, cmd_ready}, 64'h0);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_inst_valid", {63'h0, inst_valid}, 64'h0);
    check_eq("mid_rst_cmd_ready", {63'h0, cmd_ready}, 64'h0);
    check_eq("mid_rst_err_count", {56'h0, err_count}, 64'h0);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("post_rst_no_word", {63'h0, inst_valid}, 64'h0);
    end
    @(posedge clock);
    #1 inst_ready = 1'b1;
    send_model(K_OR, 5'd7, 5'd8, 5'd9, 6'd0, 32'h0, 1'b0);
    drain();

    // Error counter saturates at all-ones
    for (int i = 0; i < 260; i++) begin
      send(6'd50, 5'd0, 5'd0, 5'd0, 6'd0, 32'h0, 0, '0, '0);
    end
    repeat (2) @(negedge clock);
    check_eq("err_count_saturate", {56'h0, err_count}, 64'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
